alu_op_driver: RTL
==================

Name: alu_op_driver

Overview:
- Sequential requester for the team's 32-bit combinational `alu` (ports A, B, ALUOp, C).
- Accepts operation requests over a valid/ready handshake, registers and drives the ALU operand/opcode ports, and samples C after a settle window.
- Returns the result over a valid/ready response channel.
- Keeps an accumulator so successive operations can chain on the previous result; sits between the datapath controller and the ALU.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- SETTLE_CYCLES, 1, cycles ALU inputs are held before C is sampled; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  driver can accept a request
- req_a  input  WIDTH  operand A
- req_b  input  WIDTH  operand B
- req_op  input  3  ALU opcode
- req_chain  input  1  use accumulator instead of req_a as A
- alu_a  output  WIDTH  to ALU A
- alu_b  output  WIDTH  to ALU B
- alu_op  output  3  to ALU ALUOp
- alu_c  input  WIDTH  from ALU C
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_c  output  WIDTH  result
- rsp_err  output  1  illegal opcode flag
- busy  output  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, alu_a=0, alu_b=0, alu_op=000, rsp_valid=0, rsp_c=0, rsp_err=0, busy=0, accumulator=0, settle counter=0.
- Reset mid-operation: any in-flight request is discarded and the block returns to the reset values above.
- ALU opcode map:
  - 000 add, 001 sub (A-B), 010 and, 011 or.
  - 100 logical right shift A by B[4:0].
  - 101 arithmetic right shift A by B[4:0].
  - 110 and 111 are illegal.
  - Add/sub wrap modulo 2^WIDTH.
- req_ready=1 only in IDLE. A handshake occurs when req_valid & req_ready are both high at a rising edge.
- FSM states: IDLE, DRIVE, RESP.
- IDLE, on handshake with a legal opcode:
  - Register alu_a = (req_chain ? accumulator : req_a), alu_b = req_b, alu_op = req_op.
  - Load the settle counter with SETTLE_CYCLES-1 and go to DRIVE.
- IDLE, on handshake with an illegal opcode:
  - alu_* outputs unchanged.
  - Go directly to RESP with rsp_c=0, rsp_err=1.
  - Accumulator unchanged.
- DRIVE:
  - alu_a/alu_b/alu_op held constant.
  - When the counter reaches 0: rsp_c ← alu_c, rsp_err ← 0, accumulator ← alu_c, go to RESP. Otherwise decrement the counter.
- RESP:
  - rsp_valid=1; rsp_c and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid←0, go to IDLE.
  - No new request is accepted in the same cycle; the earliest next accept is the following cycle.
- Latency with SETTLE_CYCLES=1: request accepted at edge N, ALU inputs valid after N, rsp_valid high after edge N+2.
  - General case: N+1+SETTLE_CYCLES.
  - Illegal opcode: N+1.
- alu_* outputs keep their last driven value in IDLE and RESP; no glitching between requests.
- busy = (state != IDLE).
- req_chain on the first request after reset uses accumulator=0.
- rsp_ready held high continuously: each response lasts exactly one cycle.

Optional Feature:
- Macro: ALU_OP_DRIVER_COUNT_EN.
- Defined:
  - Adds output port `op_count` (16 bits).
  - Increments by 1 on every completed response handshake, illegal ones included.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then req A=32'hF0000000, B=32'h0000000F, op=101, rsp_ready=1 -> alu_a/alu_b/alu_op driven one cycle after accept; rsp_valid two cycles after accept with rsp_c=32'hFFFFE000, rsp_err=0.
- Chain: req A=5, B=3, op=000, then req_chain=1, B=10, op=001 -> first rsp_c=8, second rsp_c=32'hFFFFFFFE.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_c stable, req_ready=0 throughout; rsp_ready=1 -> rsp_valid drops next edge and req_ready returns high.
- Illegal op=110 with A=1, B=1 -> rsp_valid one cycle after accept, rsp_c=0, rsp_err=1, alu_op still previous value, accumulator unchanged (next chained add of B=0 returns prior result).
- Reset asserted while in DRIVE with SETTLE_CYCLES=3 -> next edge all outputs at reset values, no rsp_valid pulse, req_ready=1.
- With ALU_OP_DRIVER_COUNT_EN: 3 completed ops (one illegal) -> op_count=3; reset -> 0.

Source files
------------

// File: rtl/alu_op_driver.sv
// alu_op_driver: sequential requester for the 32-bit combinational ALU.
//
// A request arrives over a valid/ready handshake. The block registers the
// operands and opcode onto the ALU ports and holds them for SETTLE_CYCLES.
// It then samples the ALU result C and returns it over a valid/ready
// response channel.
//
// The block keeps an accumulator so that a request can chain on the
// previous result by using it as operand A. Illegal opcodes (110, 111) do
// not touch the ALU; they answer with rsp_c = 0 and rsp_err = 1.
//
// Optional feature: define ALU_OP_DRIVER_COUNT_EN to add a 16-bit op_count
// output. It counts completed response handshakes and saturates at 16'hFFFF.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_a, req_b, req_op  operands and ALU opcode
//   req_chain             use the accumulator instead of req_a as A
//   alu_a, alu_b, alu_op  registered drive to the ALU
//   alu_c                 ALU result
//   rsp_valid/rsp_ready   response handshake
//   rsp_c, rsp_err        result and illegal-opcode flag
//   op_count              completed responses (ALU_OP_DRIVER_COUNT_EN only)
//   busy                  FSM not idle
module alu_op_driver #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    input  logic             req_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_err,
`ifdef ALU_OP_DRIVER_COUNT_EN
    output logic [15:0]      op_count,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             illegal_op;
    logic             rsp_done;

    // Opcodes 110 and 111 are the only illegal encodings.
    assign illegal_op = (req_op[2:1] == 2'b11);
    assign rsp_done   = (state_q == StResp) && rsp_ready;

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        rsp_c_d   = rsp_c_q;
        rsp_err_d = rsp_err_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (illegal_op) begin
                        // The ALU ports keep their previous values.
                        rsp_c_d   = '0;
                        rsp_err_d = 1'b1;
                        state_d   = StResp;
                    end else begin
                        alu_a_d  = req_chain ? acc_q : req_a;
                        alu_b_d  = req_b;
                        alu_op_d = req_op;
                        cnt_d    = CntInit;
                        state_d  = StDrive;
                    end
                end
            end
            StDrive: begin
                if (cnt_q == 4'd0) begin
                    rsp_c_d   = alu_c;
                    rsp_err_d = 1'b0;
                    acc_d     = alu_c;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= 3'b000;
            rsp_c_q   <= '0;
            rsp_err_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            rsp_c_q   <= rsp_c_d;
            rsp_err_q <= rsp_err_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ALU_OP_DRIVER_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (rsp_done && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign op_count = count_q;
`else
    logic unused_rsp_done;
    assign unused_rsp_done = rsp_done;
`endif

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_err   = rsp_err_q;

endmodule
